// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver.
// The frame format is set by CLKS_PER_BIT, DATA_BITS, STOP_BITS and PARITY_ODD.
// Define UART_RX_PARITY_EN to compile in the parity bit and o_Parity_Err.
// Without that macro the parity bit is not expected and o_Parity_Err is tied to 0.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  // Reject illegal configurations at elaboration time.
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 2047) begin : g_bad_clks
    $error("uart_rx_param: CLKS_PER_BIT must be 4..2047");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_rx_param: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_rx_param: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             stop_idx;
  logic             stop_err;
  logic             armed;     // line has been seen high since the last frame
  logic             bit_end;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_acc;
  logic par_err;
`endif

  assign bit_end = (cnt == BIT_CNT);

  // Two-flop synchroniser; both flops reset to the idle level.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (armed && !rx_sync) next_state = S_START;
      end
      S_START: begin
        if (cnt == HALF_CNT) next_state = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_end && (idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
          next_state = S_PARITY;
`else
          next_state = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) next_state = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end && (stop_idx == LAST_STOP)) next_state = S_CLEANUP;
      end
      S_CLEANUP: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Bit timing, data capture and frame status.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      stop_idx    <= 1'b0;
      stop_err    <= 1'b0;
      armed       <= 1'b0;
      o_Rx_DV     <= 1'b0;
      o_Rx_Byte   <= '0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc      <= 1'b0;
      par_err      <= 1'b0;
      o_Parity_Err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          idx      <= '0;
          stop_idx <= 1'b0;
          stop_err <= 1'b0;
          if (rx_sync) armed <= 1'b1;
`ifdef UART_RX_PARITY_EN
          par_acc <= 1'b0;
          par_err <= 1'b0;
`endif
        end
        S_START: begin
          if (cnt == HALF_CNT) cnt <= '0;
          else                 cnt <= cnt + 1'b1;
        end
        S_DATA: begin
          if (bit_end) begin
            cnt            <= '0;
            o_Rx_Byte[idx] <= rx_sync;
            idx            <= idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            par_acc <= par_acc ^ rx_sync;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            par_err <= ((par_acc ^ rx_sync) != PAR_ODD);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (stop_idx == LAST_STOP) begin
              // A low final stop keeps the receiver disarmed until the line rises.
              o_Rx_DV     <= 1'b1;
              o_Frame_Err <= stop_err | ~rx_sync;
              armed       <= rx_sync;
`ifdef UART_RX_PARITY_EN
              o_Parity_Err <= par_err;
`endif
            end else begin
              stop_idx <= 1'b1;
              stop_err <= stop_err | ~rx_sync;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CLEANUP: begin
          o_Rx_DV     <= 1'b0;
          o_Frame_Err <= 1'b0;
          if (rx_sync) armed <= 1'b1;
`ifdef UART_RX_PARITY_EN
          o_Parity_Err <= 1'b0;
`endif
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    o_Busy = (state != S_IDLE);
  end

`ifndef UART_RX_PARITY_EN
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param.
// Two receivers run side by side: the default 8-bit / 1-stop build and a
// 5-bit / 2-stop / odd-parity build with a short bit period.
module tb_uart_rx_param;

  localparam int C0 = 87;
  localparam int C1 = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] b;
    logic       fe;
    logic       pe;
    int         t;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stopb;
    logic [7:0] eb;
    logic       ef;
    logic       ep;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic       dv0, fe0, pe0, busy0;
  logic [7:0] byte0;
  logic       dv1, fe1, pe1, busy1;
  logic [4:0] byte1;

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  wid_err = 0;
  logic dv0_q = 1'b0;
  logic dv1_q = 1'b0;
  ev_t q0[$];
  ev_t q1[$];

  always #5 clk = ~clk;

  uart_rx_param u0 (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_Rx_Serial  (rx0),
    .o_Rx_DV      (dv0),
    .o_Rx_Byte    (byte0),
    .o_Frame_Err  (fe0),
    .o_Parity_Err (pe0),
    .o_Busy       (busy0)
  );

  uart_rx_param #(
    .CLKS_PER_BIT (C1),
    .DATA_BITS    (5),
    .STOP_BITS    (2),
    .PARITY_ODD   (1)
  ) u1 (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_Rx_Serial  (rx1),
    .o_Rx_DV      (dv1),
    .o_Rx_Byte    (byte1),
    .o_Frame_Err  (fe1),
    .o_Parity_Err (pe1),
    .o_Busy       (busy1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every data-valid pulse and flag any pulse longer than one cycle.
  always @(negedge clk) begin
    if (dv0) begin
      q0.push_back('{b: byte0, fe: fe0, pe: pe0, t: cyc});
      if (dv0_q) wid_err <= wid_err + 1;
    end
    if (dv1) begin
      q1.push_back('{b: {3'b000, byte1}, fe: fe1, pe: pe1, t: cyc});
      if (dv1_q) wid_err <= wid_err + 1;
    end
    dv0_q <= dv0;
    dv1_q <= dv1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic idle(input int which, input int n);
    drive(which, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  function automatic int frame_len(input int which);
    if (which == 0) return C0 * (1 + 8 + int'(PAR_EN) + 1);
    return C1 * (1 + 5 + int'(PAR_EN) + 2);
  endfunction

  // Parity rule: the data ones plus the parity bit must match the chosen sense.
  function automatic logic model_perr(input logic [7:0] d, input int nb, input logic pb,
                                      input logic odd);
    int ones;
    if (!PAR_EN) return 1'b0;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return (((ones + int'(pb)) % 2) != int'(odd));
  endfunction

  task automatic send(input int which, input logic [7:0] d, input logic pb,
                      input logic s0, input logic s1, output int t0);
    int c, nb;
    c  = (which == 0) ? C0 : C1;
    nb = (which == 0) ? 8 : 5;
    @(negedge clk);
    t0 = cyc;
    drive(which, 1'b0);
    repeat (c) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      drive(which, d[i]);
      repeat (c) @(negedge clk);
    end
    if (PAR_EN) begin
      drive(which, pb);
      repeat (c) @(negedge clk);
    end
    drive(which, s0);
    repeat (c) @(negedge clk);
    if (which == 1) begin
      drive(which, s1);
      repeat (c) @(negedge clk);
    end
  endtask

  // The pulse must land between the middle of the last stop bit and its end.
  task automatic expect_frame(input int which, input string name, input logic [7:0] eb,
                              input logic ef, input logic ep, input int t0);
    int  c, tot, n;
    bit  got;
    ev_t e;
    c   = (which == 0) ? C0 : C1;
    tot = frame_len(which);
    got = 1'b0;
    for (int k = 0; k < 2 * c && !got; k++) begin
      n = (which == 0) ? q0.size() : q1.size();
      if (n > 0) got = 1'b1;
      else       @(negedge clk);
    end
    chk({name, "_dv"}, 32'(got), 32'd1);
    if (got) begin
      if (which == 0) e = q0.pop_front();
      else            e = q1.pop_front();
      chk({name, "_byte"}, 32'(e.b), 32'(eb));
      chk({name, "_ferr"}, 32'(e.fe), 32'(ef));
      chk({name, "_perr"}, 32'(e.pe), 32'(ep));
      chk_range({name, "_time"}, e.t - t0, tot - c / 2 - 1, tot + 4);
      n = (which == 0) ? q0.size() : q1.size();
      chk({name, "_single"}, 32'(n), 32'd0);
    end
  endtask

  initial begin
    vec_t       tv[8];
    int         t0, bcnt;
    logic [7:0] d;
    logic       pb, s0, s1;

    tv[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tv[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    tv[2] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b0, PAR_EN};
    tv[3] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tv[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tv[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, PAR_EN};
    tv[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    tv[7] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, PAR_EN};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_dv0", 32'(dv0), 32'd0);
    chk("rst_byte0", 32'(byte0), 32'd0);
    chk("rst_ferr0", 32'(fe0), 32'd0);
    chk("rst_perr0", 32'(pe0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_byte1", 32'(byte1), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(0, tv[i].data, tv[i].pbit, tv[i].stopb, 1'b1, t0);
      expect_frame(0, $sformatf("vec%0d", i), tv[i].eb, tv[i].ef, tv[i].ep, t0);
      idle(0, 2 * C0);
    end

    repeat (500) @(negedge clk);
    chk("byte_hold", 32'(byte0), 32'h01);

    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      s0 = ($urandom_range(0, 3) != 0);
      send(0, d, pb, s0, 1'b1, t0);
      expect_frame(0, $sformatf("rnd0_%0d", i), d, ~s0, model_perr(d, 8, pb, 1'b0), t0);
      idle(0, C0 + $urandom_range(0, 40));
    end

    // Short low glitch on an idle line.
    bcnt = 0;
    @(negedge clk);
    rx0 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k == 20) rx0 = 1'b1;
      @(negedge clk);
      if (busy0) bcnt++;
    end
    chk_range("glitch_busy_len", bcnt, 1, 45);
    chk("glitch_nodv", 32'(q0.size()), 32'd0);
    chk("glitch_idle", 32'(busy0), 32'd0);

    // Framing error with the line then held low for several frame times.
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1, t0);
    expect_frame(0, "hold_low", 8'h3C, 1'b1, 1'b0, t0);
    repeat (3000) @(negedge clk);
    chk("hold_low_nodup", 32'(q0.size()), 32'd0);
    idle(0, 2 * C0);
    send(0, 8'hC3, 1'b0, 1'b1, 1'b1, t0);
    expect_frame(0, "rearm", 8'hC3, 1'b0, model_perr(8'hC3, 8, 1'b0, 1'b0), t0);
    idle(0, 2 * C0);

    // Reset pulsed in the middle of data bit 4.
    d = 8'hFF;
    @(negedge clk);
    rx0 = 1'b0;
    repeat (C0) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx0 = d[i];
      repeat (C0) @(negedge clk);
    end
    rx0 = d[4];
    repeat (C0 / 2) @(negedge clk);
    chk("midrst_busy_pre", 32'(busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dv", 32'(dv0), 32'd0);
    chk("midrst_byte", 32'(byte0), 32'd0);
    chk("midrst_ferr", 32'(fe0), 32'd0);
    chk("midrst_perr", 32'(pe0), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rx0 = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 2 * C0);
    chk("midrst_nodv", 32'(q0.size()), 32'd0);
    send(0, 8'h5A, 1'b0, 1'b1, 1'b1, t0);
    expect_frame(0, "after_rst", 8'h5A, 1'b0, model_perr(8'h5A, 8, 1'b0, 1'b0), t0);
    idle(0, 2 * C0);

    // Five data bits, two stop bits, odd parity.
    send(1, 8'h15, 1'b0, 1'b1, 1'b1, t0);
    expect_frame(1, "d5_15", 8'h15, 1'b0, model_perr(8'h15, 5, 1'b0, 1'b1), t0);
    idle(1, 2 * C1);
    send(1, 8'h0A, 1'b1, 1'b0, 1'b1, t0);
    expect_frame(1, "d5_stop1low", 8'h0A, 1'b1, model_perr(8'h0A, 5, 1'b1, 1'b1), t0);
    idle(1, 2 * C1);
    send(1, 8'h1F, 1'b0, 1'b1, 1'b0, t0);
    expect_frame(1, "d5_stop2low", 8'h1F, 1'b1, model_perr(8'h1F, 5, 1'b0, 1'b1), t0);
    idle(1, 2 * C1);
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom_range(0, 31));
      pb = 1'($urandom);
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      send(1, d, pb, s0, s1, t0);
      expect_frame(1, $sformatf("rnd1_%0d", i), d, ~(s0 & s1), model_perr(d, 5, pb, 1'b1), t0);
      idle(1, C1 + $urandom_range(0, 20));
    end

    repeat (100) @(negedge clk);
    chk("dv_width", 32'(wid_err), 32'd0);
    chk("no_stray_dv", 32'(q0.size() + q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
